// File: rtl/sev_seg_pkg.sv
// Shared types and the hex glyph table for the multiplexed 7-segment scan controller.
package sev_seg_pkg;

  typedef enum logic {
    ST_DEAD = 1'b0,
    ST_ON   = 1'b1
  } scan_state_e;

  // Returns active-high segments in gfedcba order.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sev_seg_slot_timer.sv
// Slot counter and digit index for the scan; flags the last cycle of the last slot of a frame.
module sev_seg_slot_timer #(
  parameter int NUM_DIGITS  = 8,
  parameter int SLOT_CYCLES = 50000,
  localparam int CNT_W = $clog2(SLOT_CYCLES),
  localparam int IDX_W = $clog2(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] cnt,
  output logic [IDX_W-1:0] idx,
  output logic             frame_end
);

  logic [CNT_W-1:0] cnt_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             slot_end;

  assign slot_end  = (cnt_reg == CNT_W'(SLOT_CYCLES - 1));
  assign frame_end = slot_end && (idx_reg == IDX_W'(NUM_DIGITS - 1));
  assign cnt       = cnt_reg;
  assign idx       = idx_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
      idx_reg <= '0;
    end else if (slot_end) begin
      cnt_reg <= '0;
      idx_reg <= frame_end ? '0 : idx_reg + 1'b1;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/sev_seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: frame-synchronous double buffer, PWM brightness,
// anti-ghost dead time, leading-zero blanking and a registered frame pulse.
module sev_seg_scan_ctrl
  import sev_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int SLOT_CYCLES = 50000,
  parameter int DEAD_CYCLES = 2,
  parameter int PWM_BITS    = 4,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    load_i,
  input  logic [PWM_BITS-1:0]     brightness_i,
  input  logic                    lz_blank_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0]      DEAD_C = CNT_W'(DEAD_CYCLES);
  localparam logic [PWM_BITS-1:0]   DEAD_P = PWM_BITS'(DEAD_CYCLES);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACT_LOW != 0) ? '1 : '0;
  localparam logic [6:0]            SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = (SEG_ACT_LOW != 0);

  if (SLOT_CYCLES < DEAD_CYCLES + 2 ** PWM_BITS) begin : g_bad_params
    $error("SLOT_CYCLES must cover DEAD_CYCLES plus one full PWM period");
  end

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             frame_end;

  sev_seg_slot_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .SLOT_CYCLES(SLOT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .cnt      (cnt),
    .idx      (idx),
    .frame_end(frame_end)
  );

  logic [4*NUM_DIGITS-1:0] disp_val_reg, pend_val_reg;
  logic [NUM_DIGITS-1:0]   disp_dp_reg, pend_dp_reg;
  logic                    pend_flag_reg;
  logic [PWM_BITS-1:0]     bri_reg;

  // The display buffer only changes on the frame boundary, so a frame never tears.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_val_reg  <= '0;
      disp_dp_reg   <= '0;
      pend_val_reg  <= '0;
      pend_dp_reg   <= '0;
      pend_flag_reg <= 1'b0;
      bri_reg       <= '0;
    end else begin
      if (cnt == '0) bri_reg <= brightness_i;
      if (frame_end) begin
        pend_flag_reg <= 1'b0;
        if (load_i) begin
          disp_val_reg <= value_i;
          disp_dp_reg  <= dp_i;
        end else if (pend_flag_reg) begin
          disp_val_reg <= pend_val_reg;
          disp_dp_reg  <= pend_dp_reg;
        end
      end else if (load_i) begin
        pend_val_reg  <= value_i;
        pend_dp_reg   <= dp_i;
        pend_flag_reg <= 1'b1;
      end
    end
  end

  scan_state_e         scan_state;
  logic [PWM_BITS-1:0] bri_eff, pwm_phase;
  logic [NUM_DIGITS-1:0] blank_vec, an_on;
  logic [3:0]          digit_nib;
  logic                lit;
  logic [6:0]          seg_on, seg_next;
  logic [NUM_DIGITS-1:0] an_next;
  logic                dp_next;

  assign scan_state = (cnt < DEAD_C) ? ST_DEAD : ST_ON;
  // Brightness is taken live in the first cycle so a zero dead time still sees the new value.
  assign bri_eff    = (cnt == '0) ? brightness_i : bri_reg;
  assign pwm_phase  = cnt[PWM_BITS-1:0] - DEAD_P;
  assign digit_nib  = disp_val_reg[4*idx +: 4];

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    if (gi == 0) begin : g_first
      assign blank_vec[gi] = 1'b0;
    end else begin : g_upper
      assign blank_vec[gi] = lz_blank_i && (disp_val_reg[4*NUM_DIGITS-1:4*gi] == '0);
    end
    assign an_on[gi] = lit && (idx == IDX_W'(gi));
  end

  assign lit      = (scan_state == ST_ON) && (pwm_phase < bri_eff) && !blank_vec[idx];
  assign seg_on   = lit ? hex_to_seg(digit_nib) : 7'h00;
  assign seg_next = (SEG_ACT_LOW != 0) ? ~seg_on : seg_on;
  assign an_next  = (AN_ACT_LOW != 0) ? ~an_on : an_on;
  assign dp_next  = (lit && disp_dp_reg[idx]) ^ DP_OFF;

  always_ff @(posedge clk) begin
    if (reset) begin
      an_o    <= AN_OFF;
      seg_o   <= SEG_OFF;
      dp_o    <= DP_OFF;
      frame_o <= 1'b0;
    end else begin
      an_o    <= an_next;
      seg_o   <= seg_next;
      dp_o    <= dp_next;
      frame_o <= frame_end;
    end
  end

endmodule
